// File: rtl/imm_insn_encoder.sv
// Packs an immediate and register/opcode fields into an RV32 instruction word (I/S/B/J/U),
// and expands the LI pseudo-op into LUI and/or ADDI through a one-entry output slot.
module imm_insn_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] insn,
    output logic        range_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned LO_W   = 12;
    localparam int unsigned HI_W   = 20;
    localparam int unsigned REG_W  = 5;

    localparam logic [2:0] SRC_I  = 3'b000;
    localparam logic [2:0] SRC_S  = 3'b001;
    localparam logic [2:0] SRC_B  = 3'b010;
    localparam logic [2:0] SRC_J  = 3'b011;
    localparam logic [2:0] SRC_U  = 3'b100;
    localparam logic [2:0] SRC_LI = 3'b101;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [4:0] X0     = 5'd0;

    typedef enum logic {
        IDLE,
        LI2
    } state_t;

    state_t            state;
    logic [REG_W-1:0]  li_rd;
    logic [LO_W-1:0]   li_lo;

    logic              slot_free_c;
    logic              accept_c;
    logic [XLEN-1:0]   enc_word_c;
    logic              enc_err_c;
    logic              li_two_c;
    logic [HI_W-1:0]   li_hi_c;
    logic              fits_i_c;
    logic              fits_b_c;
    logic              fits_j_c;
    logic [XLEN-1:0]   addi_word_c;

    // Slot can take a new word when empty or being drained this cycle.
    assign slot_free_c = !out_valid || out_ready;
    assign in_ready    = rst && (state == IDLE) && slot_free_c;
    assign accept_c    = in_valid && in_ready;

    // Immediate range predicates: value must survive truncation and re-sign-extension.
    assign fits_i_c = (imm == {{20{imm[11]}}, imm[11:0]});
    assign fits_b_c = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
    assign fits_j_c = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];

    // LUI upper part is rounded so the sign-extended ADDI low part lands on imm.
    assign li_hi_c = imm[31:12] + HI_W'(imm[11]);

    assign addi_word_c = {li_lo, li_rd, F3_ADD, li_rd, OP_IMM};

    // Encode the first (or only) word for the request on the input port.
    always_comb begin
        enc_word_c = '0;
        enc_err_c  = 1'b0;
        li_two_c   = 1'b0;
        case (imm_src)
            SRC_I: begin
                enc_word_c = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err_c  = !fits_i_c;
            end
            SRC_S: begin
                enc_word_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err_c  = !fits_i_c;
            end
            SRC_B: begin
                enc_word_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err_c  = !fits_b_c;
            end
            SRC_J: begin
                enc_word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err_c  = !fits_j_c;
            end
            SRC_U: begin
                enc_word_c = {imm[31:12], rd, opcode};
                enc_err_c  = (imm[11:0] != '0);
            end
            SRC_LI: begin
                if (fits_i_c) begin
                    enc_word_c = {imm[11:0], X0, F3_ADD, rd, OP_IMM};
                end else begin
                    enc_word_c = {li_hi_c, rd, OP_LUI};
                    li_two_c   = (imm[11:0] != '0);
                end
            end
            default: begin
                enc_word_c = '0;
                enc_err_c  = 1'b1;
            end
        endcase
    end

    // Output slot and LI sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            insn      <= '0;
            range_err <= 1'b0;
            li_rd     <= '0;
            li_lo     <= '0;
        end else begin
            if (accept_c) begin
                out_valid <= 1'b1;
                insn      <= enc_word_c;
                range_err <= enc_err_c;
                if (li_two_c) begin
                    state <= LI2;
                    li_rd <= rd;
                    li_lo <= imm[11:0];
                end
            end else if ((state == LI2) && slot_free_c) begin
                out_valid <= 1'b1;
                insn      <= addi_word_c;
                range_err <= 1'b0;
                state     <= IDLE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_insn_encoder.sv
// Scoreboard bench for imm_insn_encoder: directed vectors plus random requests
// checked against an arithmetic reference model.
module tb_imm_insn_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_src = '0;
    logic [31:0] imm = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] insn;
    logic        range_err;

    typedef struct packed {
        logic [31:0] w;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_rdy = 1'b0;

    imm_insn_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .insn      (insn),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction words built from field values with shifts and masks,
    // range decisions made on the signed integer value of the immediate.
    task automatic push_model(input logic [2:0] s, input logic [31:0] im, input logic [6:0] op,
                              input logic [2:0] f3, input logic [4:0] d, input logic [4:0] r1,
                              input logic [4:0] r2);
        int          v;
        logic [31:0] w, hi, lo;
        logic [31:0] wop, wf3, wd, wr1, wr2;
        bit          e;
        v   = $signed(im);
        wop = 32'(op);
        wf3 = 32'(f3) << 12;
        wd  = 32'(d) << 7;
        wr1 = 32'(r1) << 15;
        wr2 = 32'(r2) << 20;
        e   = 1'b0;
        w   = '0;
        case (s)
            3'd0: begin
                e = !(v >= -2048 && v <= 2047);
                w = (im << 20) | wr1 | wf3 | wd | wop;
            end
            3'd1: begin
                e = !(v >= -2048 && v <= 2047);
                w = (((im >> 5) & 32'h7f) << 25) | wr2 | wr1 | wf3 | ((im & 32'h1f) << 7) | wop;
            end
            3'd2: begin
                e = !(v >= -4096 && v <= 4094 && (v % 2) == 0);
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3f) << 25) | wr2 | wr1 | wf3
                  | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 32'h1) << 7) | wop;
            end
            3'd3: begin
                e = !(v >= -1048576 && v <= 1048574 && (v % 2) == 0);
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3ff) << 21)
                  | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hff) << 12) | wd | wop;
            end
            3'd4: begin
                e = (im % 4096) != 0;
                w = (im & 32'hfffff000) | wd | wop;
            end
            3'd5: begin
                if (v >= -2048 && v <= 2047) begin
                    w = (im << 20) | wd | 32'h13;
                end else begin
                    hi = (im + 32'h800) >> 12;
                    lo = (im - (hi << 12)) & 32'hfff;
                    w  = (hi << 12) | wd | 32'h37;
                    if (lo != 0) begin
                        sb.push_back('{w: w, err: 1'b0});
                        w = (lo << 20) | (32'(d) << 15) | wd | 32'h13;
                    end
                end
            end
            default: begin
                e = 1'b1;
                w = '0;
            end
        endcase
        sb.push_back('{w: w, err: e});
    endtask

    // Issue one request; call at posedge+1. Expected words are either literal (n_lit>0) or modelled.
    task automatic send(input logic [2:0] s, input logic [31:0] im, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] d, input logic [4:0] r1,
                        input logic [4:0] r2, input int n_lit, input logic [31:0] w0,
                        input logic e0, input logic [31:0] w1, input logic e1);
        int  cnt;
        bit  ok;
        imm_src  = s;
        imm      = im;
        opcode   = op;
        funct3   = f3;
        rd       = d;
        rs1      = r1;
        rs2      = r2;
        in_valid = 1'b1;
        cnt = 0;
        ok  = 1'b0;
        while (!ok && cnt < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cnt++;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 100 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (n_lit == 0) push_model(s, im, op, f3, d, r1, r2);
        else begin
            sb.push_back('{w: w0, err: e0});
            if (n_lit > 1) sb.push_back('{w: w1, err: e1});
        end
    endtask

    task automatic drain();
        int cnt;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while (sb.size() != 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Random consumer backpressure, applied after the main thread's edge+1 drives.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) out_ready = ($urandom % 4) != 0;
        end
    end

    // Monitor: every completed output transfer pops and compares one expected word.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected no output", insn);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("insn", insn, e.w);
                check("range_err", 32'(range_err), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] bvals [18] = '{32'd0, 32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                32'd4094, 32'd4095, 32'd4096, 32'hFFFFF000, 32'hFFFFEFFE,
                                32'd1048574, 32'd1048576, 32'hFFF00000, 32'h7FFFF800,
                                32'h7FFFFFFF, 32'h80000000, 32'h800, 32'hFFFFFFFF};

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_insn", insn, 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Directed encodings
        send(3'd0, 32'hFFFFFFFF, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 1, 32'hFFF10093, 1'b0, 32'h0, 1'b0);
        send(3'd2, 32'hFFFFFFFC, 7'h63, 3'd0, 5'd31, 5'd1, 5'd2, 1, 32'hFE208EE3, 1'b0, 32'h0, 1'b0);
        send(3'd2, 32'h00000002, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 1, 32'h00208163, 1'b0, 32'h0, 1'b0);
        send(3'd2, 32'h00001001, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 1, 32'h80208063, 1'b1, 32'h0, 1'b0);
        send(3'd0, 32'd2048, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 1, 32'h80010093, 1'b1, 32'h0, 1'b0);
        send(3'd6, 32'h12345678, 7'h13, 3'd1, 5'd1, 5'd2, 5'd3, 1, 32'h0, 1'b1, 32'h0, 1'b0);
        send(3'd5, 32'h00005000, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 1, 32'h000052B7, 1'b0, 32'h0, 1'b0);
        send(3'd5, 32'h00000800, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 2, 32'h000012B7, 1'b0, 32'h80028293, 1'b0);
        drain();

        // Two-word LI: second word on the following cycle, no accept meanwhile
        send(3'd5, 32'h12345678, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 2, 32'h123452B7, 1'b0, 32'h67828293, 1'b0);
        @(negedge clk);
        check("li2_in_ready", 32'(in_ready), 32'd0);
        check("li2_first_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("li2_second_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: word held, no accept while stalled, then drain+accept in one cycle
        out_ready = 1'b0;
        send(3'd0, 32'd5, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 1, 32'h00520193, 1'b0, 32'h0, 1'b0);
        imm      = 32'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_insn", insn, 32'h00520193);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd0, 32'd7, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 1, 32'h00720193, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("bp_new_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Reset in the middle of a two-word LI
        out_ready = 1'b0;
        send(3'd5, 32'h12345678, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 2, 32'h123452B7, 1'b0, 32'h67828293, 1'b0);
        @(negedge clk);
        check("mid_li_valid", 32'(out_valid), 32'd1);
        check("mid_li_insn", insn, 32'h123452B7);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_insn", insn, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;

        // Random requests under random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  s;
            logic [31:0] im;
            int          m;
            s = ($urandom % 8 < 6) ? 3'($urandom % 6) : 3'($urandom % 8);
            m = $urandom % 5;
            case (m)
                0: im = $urandom;
                1: im = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: im = bvals[$urandom % 18];
                3: im = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: im = 32'($urandom) & 32'hfffff000;
            endcase
            send(s, im, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 0, 32'h0, 1'b0, 32'h0, 1'b0);
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
